cache_invalidator: RTL and testbench

CACHE_INVALIDATOR -- requirements
Module: cache_invalidator

---
 rtl/cache_invalidator.sv | 94 +++++++++
 tb/tb_cache_invalidator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_invalidator.sv
// Walks the valid-bit memory clearing lines: either the whole cache (flush) or one line,
// sharing the write port through an external arbiter grant.
module cache_invalidator #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  invalidate_i,
    input  logic [ADDR_WIDTH-1:0] invalidate_address_i,
    input  logic                  port_granted_i,
    output logic                  ready_o,
    output logic                  port_request_o,
    output logic                  write_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic                  valid_o,
    output logic                  done_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSweep  = 2'd1;
    localparam logic [1:0] StSingle = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LastLine = '1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                // Flush wins; a simultaneous single invalidate is dropped.
                if (flush_i) begin
                    state_d = StSweep;
                    count_d = '0;
                end else if (invalidate_i) begin
                    state_d = StSingle;
                    addr_d  = invalidate_address_i;
                end
            end
            StSweep: begin
                if (port_granted_i) begin
                    count_d = count_q + ADDR_WIDTH'(1);
                    if (count_q == LastLine) begin
                        state_d = StDone;
                    end
                end
            end
            StSingle: begin
                if (port_granted_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        ready_o        = (state_q == StIdle);
        port_request_o = (state_q == StSweep) || (state_q == StSingle);
        write_o        = port_request_o && port_granted_i;
        valid_o        = 1'b0;
        done_o         = (state_q == StDone);
        write_address_o = '0;
        if (state_q == StSweep) begin
            write_address_o = count_q;
        end else if (state_q == StSingle) begin
            write_address_o = addr_q;
        end
    end

endmodule

// File: tb/tb_cache_invalidator.sv
// Scoreboarded bench: a 4-line instance for sweep behaviour and a 256-line instance for
// single-line addresses; expected writes/done pulses are queued and checked by monitors.
module tb_cache_invalidator;

    logic clk;

    // Small instance (ADDR_WIDTH = 2)
    logic       s_rst, s_flush, s_inv, s_gnt;
    logic [1:0] s_inv_addr;
    logic       s_ready, s_preq, s_write, s_valid, s_done;
    logic [1:0] s_waddr;

    // Default instance (ADDR_WIDTH = 8)
    logic       b_rst, b_flush, b_inv, b_gnt;
    logic [7:0] b_inv_addr;
    logic       b_ready, b_preq, b_write, b_valid, b_done;
    logic [7:0] b_waddr;

    int sq[$];
    int bq[$];
    int checks = 0;
    int errors = 0;
    int b_preq_cycles = 0;
    bit mon_en = 0;

    cache_invalidator #(.ADDR_WIDTH(2)) u_small (
        .clk_i                (clk),
        .rst_i                (s_rst),
        .flush_i              (s_flush),
        .invalidate_i         (s_inv),
        .invalidate_address_i (s_inv_addr),
        .port_granted_i       (s_gnt),
        .ready_o              (s_ready),
        .port_request_o       (s_preq),
        .write_o              (s_write),
        .write_address_o      (s_waddr),
        .valid_o              (s_valid),
        .done_o               (s_done)
    );

    cache_invalidator u_big (
        .clk_i                (clk),
        .rst_i                (b_rst),
        .flush_i              (b_flush),
        .invalidate_i         (b_inv),
        .invalidate_address_i (b_inv_addr),
        .port_granted_i       (b_gnt),
        .ready_o              (b_ready),
        .port_request_o       (b_preq),
        .write_o              (b_write),
        .write_address_o      (b_waddr),
        .valid_o              (b_valid),
        .done_o               (b_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic rdy, input logic preq,
                              input logic wr, input int wa, input logic vld, input logic dn);
        check({tag, " ready"}, int'(rdy), 1);
        check({tag, " port_request"}, int'(preq), 0);
        check({tag, " write"}, int'(wr), 0);
        check({tag, " write_address"}, wa, 0);
        check({tag, " valid"}, int'(vld), 0);
        check({tag, " done"}, int'(dn), 0);
    endtask

    // Done entries are queued as -1 so their ordering against writes is checked too.
    always @(negedge clk) begin
        int e;
        if (mon_en) begin
            check("small write=req&gnt", int'(s_write), int'(s_preq & s_gnt));
            if (s_write) begin
                check("small valid", int'(s_valid), 0);
                if (sq.size() == 0) check("small unexpected write", int'(s_waddr), -2);
                else begin
                    e = sq.pop_front();
                    check("small write address", int'(s_waddr), e);
                end
            end
            if (s_done) begin
                if (sq.size() == 0) check("small unexpected done", int'(s_done), 0);
                else begin
                    e = sq.pop_front();
                    check("small done order", -1, e);
                end
            end
            check("big write=req&gnt", int'(b_write), int'(b_preq & b_gnt));
            if (b_preq) b_preq_cycles++;
            if (b_write) begin
                check("big valid", int'(b_valid), 0);
                if (bq.size() == 0) check("big unexpected write", int'(b_waddr), -2);
                else begin
                    e = bq.pop_front();
                    check("big write address", int'(b_waddr), e);
                end
            end
            if (b_done) begin
                if (bq.size() == 0) check("big unexpected done", int'(b_done), 0);
                else begin
                    e = bq.pop_front();
                    check("big done order", -1, e);
                end
            end
        end
    end

    task automatic wait_done(input bit big, output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (big ? b_done : s_done) return;
        end
        check("done timeout", 0, 1);
    endtask

    task automatic small_flush(output int n);
        for (int a = 0; a < 4; a++) sq.push_back(a);
        sq.push_back(-1);
        @(posedge clk); #1 s_flush = 1;
        @(posedge clk); #1 s_flush = 0;
        wait_done(0, n);
    endtask

    initial begin
        int n;
        int base;
        // Reset asserted together with requests and grants: reset must win.
        s_rst = 1; s_flush = 1; s_inv = 0; s_inv_addr = 0; s_gnt = 1;
        b_rst = 1; b_flush = 0; b_inv = 1; b_inv_addr = 8'h33; b_gnt = 1;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        check_idle("small reset", s_ready, s_preq, s_write, int'(s_waddr), s_valid, s_done);
        check_idle("big reset", b_ready, b_preq, b_write, int'(b_waddr), b_valid, b_done);
        @(posedge clk); #1;
        s_rst = 0; s_flush = 0;
        b_rst = 0; b_inv = 0;
        @(negedge clk);
        check_idle("small post-reset", s_ready, s_preq, s_write, int'(s_waddr), s_valid, s_done);
        check_idle("big idle grant", b_ready, b_preq, b_write, int'(b_waddr), b_valid, b_done);

        // Sweep with continuous grant
        small_flush(n);
        check("sweep latency", n, 5);
        @(negedge clk);
        check("ready after sweep", int'(s_ready), 1);

        // Sweep with alternating grant
        for (int a = 0; a < 4; a++) sq.push_back(a);
        sq.push_back(-1);
        @(posedge clk); #1 s_flush = 1; s_gnt = 1;
        @(posedge clk); #1 s_flush = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (s_done) break;
            @(posedge clk); #1 s_gnt = ~s_gnt;
        end
        check("toggle grant latency", n, 8);
        s_gnt = 1;

        // Reset after the second sweep write aborts without done
        sq.push_back(0);
        sq.push_back(1);
        @(posedge clk); #1 s_flush = 1;
        @(posedge clk); #1 s_flush = 0;
        @(posedge clk); #1 s_rst = 1;
        @(posedge clk); #1 s_rst = 0;
        @(negedge clk);
        check("abort write", int'(s_write), 0);
        check("abort ready", int'(s_ready), 1);
        check("abort done", int'(s_done), 0);
        repeat (5) @(negedge clk);
        check("abort queue drained", sq.size(), 0);
        small_flush(n);
        check("restart latency", n, 5);

        // Single invalidate held through a sweep is accepted only afterwards
        for (int a = 0; a < 4; a++) sq.push_back(a);
        sq.push_back(-1);
        sq.push_back(2);
        sq.push_back(-1);
        @(posedge clk); #1 s_flush = 1;
        @(posedge clk); #1 s_flush = 0; s_inv = 1; s_inv_addr = 2'd2;
        wait_done(0, n);
        check("held-inv sweep latency", n, 5);
        @(negedge clk);
        check("held-inv ready", int'(s_ready), 1);
        @(posedge clk); #1 s_inv = 0;
        wait_done(0, n);
        check("held-inv single latency", n, 2);

        // Flush and invalidate together: sweep only
        for (int a = 0; a < 256; a++) bq.push_back(a);
        bq.push_back(-1);
        @(posedge clk); #1 b_flush = 1; b_inv = 1; b_inv_addr = 8'h07; b_gnt = 1;
        @(posedge clk); #1 b_flush = 0; b_inv = 0;
        wait_done(1, n);
        check("full sweep latency", n, 257);
        repeat (4) @(negedge clk);
        check("no dropped-invalidate write", bq.size(), 0);

        // Single invalidate with grant delayed by three cycles
        bq.push_back(8'h5A);
        bq.push_back(-1);
        @(posedge clk); #1 b_gnt = 0; b_inv = 1; b_inv_addr = 8'h5A;
        @(posedge clk); #1 b_inv = 0; b_inv_addr = 8'hFF;
        base = b_preq_cycles;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("single wait request", int'(b_preq), 1);
            check("single wait address", int'(b_waddr), 8'h5A);
            @(posedge clk); #1;
        end
        b_gnt = 1;
        wait_done(1, n);
        check("single latency", n, 2);
        check("single request cycles", b_preq_cycles - base, 4);

        repeat (3) @(negedge clk);
        check("small queue empty", sq.size(), 0);
        check("big queue empty", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
